// File: rtl/nlms_pkg.sv
// Shared types for the NLMS BRAM sequencer: FSM state encoding and sweep mode constants.
// Imported by the scheduler and available to the bench.
package nlms_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_RD,
    S_F_DRAIN,
    S_U_RD,
    S_U_WR,
    S_U_FLUSH
  } sched_state_e;

  localparam logic MODE_FILTER = 1'b0;
  localparam logic MODE_UPDATE = 1'b1;

  // Width helper: a zero-bit counter or index is carried as one always-zero bit.
  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/nlms_bram_sched.sv
// Sequences filter (read-only) and update (read then per-word write-back) sweeps over one coefficient BRAM.
// Read data valid 1 cycle after re; writes land 1 cycle after upd handshake; dp_ready only gates read issue.
module nlms_bram_sched
  import nlms_pkg::*;
#(
  parameter int LOG2_HEIGHT            = 5,
  parameter int WORD_WIDTH             = 16,
  parameter int LOG2_RD_PORT_NUM_WORDS = 2,
  localparam int ADDR_WIDTH            = LOG2_HEIGHT,
  localparam int BLK_WIDTH             = max1(LOG2_HEIGHT - LOG2_RD_PORT_NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  input  logic                  dp_ready,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [BLK_WIDTH-1:0]  rd_blk,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  upd_valid,
  input  logic [WORD_WIDTH-1:0] upd_data,
  output logic                  upd_ready,
  output logic                  en_wport,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [WORD_WIDTH-1:0] wdata
);

  localparam int N       = 2 ** LOG2_RD_PORT_NUM_WORDS;
  localparam int NB      = 2 ** (LOG2_HEIGHT - LOG2_RD_PORT_NUM_WORDS);
  localparam int K_WIDTH = max1(LOG2_RD_PORT_NUM_WORDS);

  localparam logic [BLK_WIDTH-1:0] BLK_LAST = BLK_WIDTH'(NB - 1);
  localparam logic [K_WIDTH-1:0]   K_LAST   = K_WIDTH'(N - 1);

  sched_state_e state, state_nxt;

  logic [BLK_WIDTH-1:0]  blk;
  logic [K_WIDTH-1:0]    k;
  logic [ADDR_WIDTH-1:0] blk_base;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  blk_last;
  logic                  k_last;
  logic                  upd_fire;
  logic                  go;
  logic                  sweep_end;
  logic                  blk_inc;
  logic                  k_inc;
  logic                  k_clr;
  logic                  rd_last_nxt;

  // Block base is blk*N; the word index fills the low bits, so the shift is a pure concatenation.
  assign blk_base = ADDR_WIDTH'(blk) << LOG2_RD_PORT_NUM_WORDS;
  assign wr_addr  = blk_base | ADDR_WIDTH'(k);
  assign raddr    = blk_base;
  assign blk_last = (blk == BLK_LAST);
  assign k_last   = (k == K_LAST);
  assign upd_fire = upd_valid && upd_ready;
  assign we       = en_wport;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    re          = 1'b0;
    upd_ready   = 1'b0;
    go          = 1'b0;
    sweep_end   = 1'b0;
    blk_inc     = 1'b0;
    k_inc       = 1'b0;
    k_clr       = 1'b0;
    rd_last_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          go        = 1'b1;
          state_nxt = (mode == MODE_FILTER) ? S_F_RD : S_U_RD;
        end
      end
      S_F_RD: begin
        re          = dp_ready;
        rd_last_nxt = blk_last;
        if (dp_ready) begin
          if (blk_last) begin
            state_nxt = S_F_DRAIN;
          end else begin
            blk_inc = 1'b1;
          end
        end
      end
      S_F_DRAIN: begin
        sweep_end = 1'b1;
        state_nxt = S_IDLE;
      end
      S_U_RD: begin
        re          = dp_ready;
        rd_last_nxt = blk_last;
        if (dp_ready) begin
          k_clr     = 1'b1;
          state_nxt = S_U_WR;
        end
      end
      S_U_WR: begin
        upd_ready = 1'b1;
        if (upd_valid) begin
          if (k_last) begin
            k_clr = 1'b1;
            if (blk_last) begin
              state_nxt = S_U_FLUSH;
            end else begin
              blk_inc   = 1'b1;
              state_nxt = S_U_RD;
            end
          end else begin
            k_inc = 1'b1;
          end
        end
      end
      S_U_FLUSH: begin
        sweep_end = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      blk <= '0;
      k   <= '0;
    end else if (go) begin
      blk <= '0;
      k   <= '0;
    end else begin
      if (blk_inc) begin
        blk <= blk + BLK_WIDTH'(1);
      end
      if (k_clr) begin
        k <= '0;
      end else if (k_inc) begin
        k <= k + K_WIDTH'(1);
      end
    end
  end

  // done is registered so it trails the final read/write by one cycle; busy drops on the same edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= sweep_end;
      if (go) begin
        busy <= 1'b1;
      end else if (sweep_end) begin
        busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_blk   <= '0;
    end else begin
      rd_valid <= re;
      rd_last  <= re && rd_last_nxt;
      if (re) begin
        rd_blk <= blk;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_wport <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      en_wport <= upd_fire;
      if (upd_fire) begin
        waddr <= wr_addr;
        wdata <= upd_data;
      end
    end
  end

endmodule

// File: doc/nlms_bram_sched.md
Name: nlms_bram_sched

Overview:
- Sequencer for one nlms_bram instance: coefficient memory, wide aligned read port, single-word write port.
- Filter sweep: streams every aligned read block to the MAC datapath.
- Update sweep: reads each block, then writes back the updated words from the adaptation datapath one at a time.
- Sits between the NLMS top-level FSM (start/mode/done) and the BRAM ports.

Parameters:
- LOG2_HEIGHT, 5, log2 of BRAM depth in words (HEIGHT=32).
- WORD_WIDTH, 16, coefficient word width.
- LOG2_RD_PORT_NUM_WORDS, 2, log2 of words per read (N=4); must be <= LOG2_HEIGHT.
- Derived localparams: NB = 2**(LOG2_HEIGHT-LOG2_RD_PORT_NUM_WORDS) blocks; ADDR_WIDTH = LOG2_HEIGHT.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  one-cycle sweep request; ignored while busy
- mode  in  1  sampled with start; 0 = filter sweep, 1 = update sweep
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse at sweep end
- dp_ready  in  1  datapath can take a block one cycle later
- rd_valid  out  1  BRAM rdata valid this cycle
- rd_last  out  1  with rd_valid: final block of sweep
- rd_blk  out  ADDR_WIDTH-LOG2_RD_PORT_NUM_WORDS (min 1)  block index of the valid rdata
- re  out  1  BRAM read enable
- raddr  out  ADDR_WIDTH  BRAM read address, always a multiple of N
- upd_valid  in  1  updated word available
- upd_data  in  WORD_WIDTH  updated word, in ascending address order within the block
- upd_ready  out  1  scheduler accepts upd_data
- en_wport  out  1  BRAM write-port enable
- we  out  1  BRAM write enable (equal to en_wport)
- waddr  out  ADDR_WIDTH  BRAM write address
- wdata  out  WORD_WIDTH  BRAM write data

Behaviour:
- Reset (async, nrst=0): state IDLE; all outputs 0; block counter blk=0; word counter k=0.
- Reset mid-sweep aborts immediately. No write is left pending: write outputs are registers and are cleared.
- BRAM read latency is 1 cycle. rd_valid(t+1) = re(t). rd_blk and rd_last are registered copies of the issuing cycle's values.
- States: IDLE, F_RD, F_DRAIN, U_RD, U_WR, U_FLUSH.
- IDLE: on start, go to F_RD (mode=0) or U_RD (mode=1). Clear blk and k; set busy next cycle.
- F_RD:
  - re = dp_ready; raddr = blk*N.
  - On re: blk++. If blk==NB-1, go to F_DRAIN.
  - dp_ready low inserts bubbles; there is no other backpressure. The datapath must accept every rd_valid.
- F_DRAIN: one cycle; last rd_valid with rd_last=1. Pulse done, clear busy, go to IDLE.
- U_RD: re = dp_ready; raddr = blk*N. On re, go to U_WR with k=0.
- U_WR:
  - upd_ready=1. rd_valid is high in the first U_WR cycle.
  - Each upd_valid&&upd_ready registers en_wport=we=1, waddr=blk*N+k, wdata=upd_data (visible the next cycle); then k++.
  - On k==N-1 accept: if blk==NB-1 go to U_FLUSH, else blk++ and go to U_RD.
  - upd_valid may be accepted in the same cycle rd_valid is high.
- U_FLUSH: final write is on the ports this cycle. Pulse done, clear busy, go to IDLE.
- Write strobes are single-cycle per accepted word; en_wport/we are 0 otherwise.
- The next block's U_RD read may overlap the last write of the previous block. Addresses are disjoint, so there is no hazard.
- start while busy: ignored, no error flag.
- Boundaries:
  - N=1: U_WR holds one word per block.
  - NB=1: F_RD goes directly to F_DRAIN after one read; rd_blk width is forced to 1 and stays 0.
- Counter widths: blk and k wrap is never reached; terminal compares end the loops.

Decomposition:
- Package nlms_pkg:
  - sched_state_e enum of the six states.
  - Mode constants MODE_FILTER=1'b0, MODE_UPDATE=1'b1.
- No sub-module; address generation (blk*N via concatenation {blk,k}) stays inline.

Test Plan (defaults: HEIGHT=32, N=4, NB=8):
- Filter, dp_ready tied 1: start,mode=0 -> raddr 0,4,...,28 on 8 consecutive cycles; rd_valid cycles 2-9 with rd_blk 0..7; rd_last only with blk 7; done the cycle after the last rd_valid.
- Filter with dp_ready toggling 1,0,1,0: reads only in ready cycles; still exactly 8 rd_valid; done after rd_blk 7.
- Update, upd_valid always 1, upd_data=0x1000+addr: all 32 words written once; waddr 0..31 ascending; BRAM contents equal 0x1000+addr; raddr for blocks 0..7 issued before their writes; done after waddr 31.
- Update with upd_valid gaps (1 valid every 3 cycles): no write without a handshake; waddr sequence unchanged; busy stays high throughout.
- nrst pulled low while in U_WR at blk 3, k 2: all outputs 0 asynchronously; after release, IDLE; a new start runs a full clean sweep.
- start asserted while busy, plus a LOG2_RD_PORT_NUM_WORDS=0 build: extra start ignored; N=1 update performs 32 read/write pairs.
